mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  32  address width
  DATA_W  32  data width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  a_req  in  1  requester A (instruction fetch) request
  a_addr  in  ADDR_W  A address
  a_ack  out  1  A transaction complete
  b_req  in  1  requester B (data access) request
  b_addr  in  ADDR_W  B address
  b_wdata  in  DATA_W  B write data
  b_we  in  1  B write enable
  b_ack  out  1  B transaction complete
  mem_req  out  1  shared port request
  mem_addr  out  ADDR_W  steered address
  mem_wdata  out  DATA_W  steered write data (zero when A granted)
  mem_we  out  1  steered write enable (0 when A granted)
  mem_ready  in  1  memory completes current access
  mem_rdata  in  DATA_W  memory read data
  rdata  out  DATA_W  read data to both requesters (mem_rdata passthrough)
  gnt_b  out  1  payload select; 1 = B drives port, 0 = A

Function
REQ-003 FSM SHALL have states IDLE, GNT_A, GNT_B, held in a registered state variable.
REQ-004 IDLE: a_req only -> GNT_A; b_req only -> GNT_B; both -> winner per REQ-010; neither -> IDLE.
REQ-005 GNT_x: mem_req=1; stay until mem_ready=1, then -> IDLE next edge.
REQ-006 x_ack SHALL be combinational: 1 exactly when state=GNT_x and mem_ready=1; single-cycle pulse.
REQ-007 Latency: req sampled in IDLE at edge N -> mem_req high after edge N; one IDLE bubble cycle between consecutive grants.
REQ-008 Payload steering SHALL follow gnt_b, which is 1 in GNT_B, 0 otherwise; mem_addr/mem_we/mem_wdata valid only while mem_req=1.
REQ-009 Requesters SHALL hold req and payload stable until ack; req dropped mid-grant -> transaction still completes, ack still pulses.
REQ-010 Default tie-break: B wins (fixed priority).
REQ-011 mem_ready while IDLE SHALL be ignored; no ack, no state change.
REQ-012 mem_ready and new request in the same cycle: ack current owner; new request arbitrated in following IDLE cycle.

Reset
REQ-013 rst_n low SHALL force immediately: state=IDLE, mem_req=0, a_ack=0, b_ack=0, gnt_b=0, last-grant pointer=B.
REQ-014 Reset mid-grant SHALL abandon the transaction with no ack; requester re-arbitrates after release.

Configuration
REQ-015 Macro MEM_ARB_RR_EN defined: tie-break is round-robin; a one-bit last-grant register, updated on each grant entry, gives the tie to the requester not last granted.
REQ-016 Macro MEM_ARB_RR_EN undefined: fixed B priority per REQ-010; no last-grant register is built.

Structure
REQ-017 Shared package SHALL hold the state enum (IDLE, GNT_A, GNT_B) and the default ADDR_W/DATA_W constants.
REQ-018 Payload steering SHALL instantiate the team's parameterized 2:1 word mux (Mux) for address and write data, select tied to gnt_b; FSM stays in the top module.

Verification
REQ-019 A only: a_req=1, a_addr=0x0040_0000, mem_ready after 2 cycles -> mem_addr=0x0040_0000, mem_we=0, one a_ack pulse, rdata=mem_rdata.
REQ-020 Simultaneous a_req/b_req, b_addr=0x1001_0000, b_we=1, b_wdata=0xDEAD_BEEF, fixed priority -> B granted first with mem_we=1; A granted after one IDLE cycle.
REQ-021 MEM_ARB_RR_EN, both requesting continuously for 4 grants -> grant order A,B,A,B starting from reset.
REQ-022 mem_ready pulsed in IDLE with no requests -> no ack, mem_req stays 0.
REQ-023 rst_n low during GNT_B before mem_ready -> mem_req 0 same cycle, no b_ack; after release, b_req still high -> GNT_B re-entered.
REQ-024 b_req dropped mid-grant -> mem_req held until mem_ready; b_ack pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Parameterized 2:1 word mux used to steer requester payloads onto the shared port.
module Mux #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch (A) and data access (B) onto one memory port.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed B priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_we,
  output logic              b_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt_b
);

  state_t state, state_nxt;
  logic   pick_b;

`ifdef MEM_ARB_RR_EN
  // 1 = B held the most recent grant; reset leaves A first in line.
  logic last_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (state == IDLE && (a_req || b_req)) begin
      last_b <= pick_b;
    end
  end

  assign pick_b = b_req && (!a_req || !last_b);
`else
  assign pick_b = b_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          state_nxt = pick_b ? GNT_B : GNT_A;
        end
      end
      GNT_A, GNT_B: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req = (state == GNT_A) || (state == GNT_B);
  assign gnt_b   = (state == GNT_B);
  assign a_ack   = (state == GNT_A) && mem_ready;
  assign b_ack   = (state == GNT_B) && mem_ready;
  assign rdata   = mem_rdata;

  // A never writes, so its write-data leg is tied to zero.
  assign mem_we  = gnt_b & b_we;

  Mux #(.W(ADDR_W)) u_addr_mux (
    .sel (gnt_b),
    .d0  (a_addr),
    .d1  (b_addr),
    .y   (mem_addr)
  );

  Mux #(.W(DATA_W)) u_wdata_mux (
    .sel (gnt_b),
    .d0  ({DATA_W{1'b0}}),
    .d1  (b_wdata),
    .y   (mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, random vs model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, b_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0, b_wdata = '0, mem_rdata = '0;
  logic        a_ack, b_ack, mem_req, mem_we, gnt_b;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int total = 0;
  int bad   = 0;

  // Model: owner 0 = nobody, 1 = A, 2 = B; last = most recent grantee.
  int own  = 0;
  int last = 2;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_addr    (a_addr),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_we      (b_we),
    .b_ack     (b_ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .gnt_b     (gnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a_req, b_req, b_we, rdy;
    logic [31:0] a_addr, b_addr, wdata, rdat;
    logic        e_req, e_gntb, e_aack, e_back;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk1("m_req",   mem_req, own != 0);
    chk1("m_gntb",  gnt_b,   own == 2);
    chk1("m_aack",  a_ack,   (own == 1) && mem_ready);
    chk1("m_back",  b_ack,   (own == 2) && mem_ready);
    chkw("m_rdata", rdata,   mem_rdata);
    if (own == 1) begin
      chkw("m_addrA",  mem_addr,  a_addr);
      chkw("m_wdataA", mem_wdata, 32'h0);
      chk1("m_weA",    mem_we,    1'b0);
    end else if (own == 2) begin
      chkw("m_addrB",  mem_addr,  b_addr);
      chkw("m_wdataB", mem_wdata, b_wdata);
      chk1("m_weB",    mem_we,    b_we);
    end
  endtask

  task automatic model_step();
    int win;
    if (own != 0) begin
      if (mem_ready) own = 0;
    end else if (a_req || b_req) begin
`ifdef MEM_ARB_RR_EN
      if (a_req && b_req) win = (last == 2) ? 1 : 2;
      else                win = b_req ? 2 : 1;
`else
      win = b_req ? 2 : 1;
`endif
      own  = win;
      last = win;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1; mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk1("rst_req",  mem_req, 1'b0);
    chk1("rst_gntb", gnt_b,   1'b0);
    chk1("rst_aack", a_ack,   1'b0);
    chk1("rst_back", b_ack,   1'b0);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0; b_we = 1'b0;
    rst_n = 1'b1;
    own = 0; last = 2;
    tick();
  endtask

  initial begin
    int grants;
    logic [3:0] order;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0000};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0000, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0000};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    do_reset();

    // Vector table: idle ready ignored, then an A-only fetch.
    for (int i = 0; i < 6; i++) begin
      a_req = tbl[i].a_req; b_req = tbl[i].b_req; b_we = tbl[i].b_we;
      mem_ready = tbl[i].rdy; a_addr = tbl[i].a_addr; b_addr = tbl[i].b_addr;
      b_wdata = tbl[i].wdata; mem_rdata = tbl[i].rdat;
      @(negedge clk);
      chk1("t_req",   mem_req, tbl[i].e_req);
      chk1("t_gntb",  gnt_b,   tbl[i].e_gntb);
      chk1("t_aack",  a_ack,   tbl[i].e_aack);
      chk1("t_back",  b_ack,   tbl[i].e_back);
      chkw("t_rdata", rdata,   tbl[i].rdat);
      if (tbl[i].e_req) begin
        chkw("t_addr", mem_addr, tbl[i].e_addr);
        chk1("t_we",   mem_we,   1'b0);
      end
      tick();
    end

    // Simultaneous requests: B first (last grant was A), bubble, then A.
    a_req = 1'b1; a_addr = 32'h0040_0000;
    b_req = 1'b1; b_addr = 32'h1001_0000; b_we = 1'b1; b_wdata = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    @(negedge clk); chk1("s_idle", mem_req, 1'b0);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("s_reqB",  mem_req,   1'b1);
    chk1("s_gntB",  gnt_b,     1'b1);
    chk1("s_weB",   mem_we,    1'b1);
    chkw("s_addrB", mem_addr,  32'h1001_0000);
    chkw("s_wdB",   mem_wdata, 32'hDEAD_BEEF);
    chk1("s_backB", b_ack,     1'b1);
    chk1("s_aack0", a_ack,     1'b0);
    tick();
    b_req = 1'b0; b_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk); chk1("s_bubble", mem_req, 1'b0);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("s_reqA",  mem_req,   1'b1);
    chk1("s_gntA",  gnt_b,     1'b0);
    chk1("s_weA",   mem_we,    1'b0);
    chkw("s_wdA",   mem_wdata, 32'h0);
    chkw("s_addrA", mem_addr,  32'h0040_0000);
    chk1("s_aack",  a_ack,     1'b1);
    tick();
    a_req = 1'b0; mem_ready = 1'b0;
    tick();

    // B drops its request mid-grant; transaction still completes once.
    b_req = 1'b1; b_addr = 32'h2000_0010;
    tick();
    @(negedge clk); chk1("d_gnt", gnt_b, 1'b1);
    tick();
    b_req = 1'b0;
    @(negedge clk);
    chk1("d_hold", mem_req, 1'b1);
    chk1("d_noack", b_ack, 1'b0);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("d_ack", b_ack, 1'b1);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk1("d_done", mem_req, 1'b0);
    chk1("d_ack1", b_ack, 1'b0);
    tick();

    // Reset during GNT_B abandons the access; B re-enters after release.
    b_req = 1'b1; b_addr = 32'h3000_0000;
    tick();
    @(negedge clk); chk1("r_gnt", gnt_b, 1'b1);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk1("r_req0", mem_req, 1'b0);
    chk1("r_back", b_ack,   1'b0);
    chk1("r_gnt0", gnt_b,   1'b0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    own = 0; last = 2;
    tick();
    @(negedge clk);
    chk1("r_regnt", gnt_b, 1'b1);
    chk1("r_rereq", mem_req, 1'b1);
    tick();
    mem_ready = 1'b1;
    @(negedge clk); chk1("r_ack", b_ack, 1'b1);
    tick();
    b_req = 1'b0; mem_ready = 1'b0;
    tick();

`ifdef MEM_ARB_RR_EN
    // Both requesting continuously from reset: grants alternate A,B,A,B.
    do_reset();
    a_req = 1'b1; b_req = 1'b1; mem_ready = 1'b1;
    grants = 0; order = '0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      @(negedge clk);
      if (mem_req) begin
        order[grants] = gnt_b;
        grants++;
      end
      tick();
    end
    chkw("rr_count", 32'(grants), 32'd4);
    chkw("rr_order", {28'h0, order}, 32'h0000_000A);
    a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0;
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      a_req     = ($urandom_range(0, 2) != 0);
      b_req     = ($urandom_range(0, 2) != 0);
      b_we      = $urandom_range(0, 1) == 1;
      mem_ready = ($urandom_range(0, 2) == 0);
      a_addr    = $urandom;
      b_addr    = $urandom;
      b_wdata   = $urandom;
      mem_rdata = $urandom;
      @(negedge clk);
      model_check();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
